reg_bank_store: RTL and testbench

//  - Architectural register storage for the single-cycle RISC-V datapath; holds the implemented

---
 rtl/reg_bank_store.sv | 91 +++++++++
 tb/tb_reg_bank_store.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_store.sv
// Register storage for the implemented RISC-V subset x0, x9, x18..x27 with one synchronous write port.
// Optional illegal-write monitor (illegal_wr / illegal_cnt) enabled by defining REGBANK_ILLEGAL_WR_EN.
module reg_bank_store #(
   parameter int unsigned          DATA_W      = 32,
   parameter logic [DATA_W-1:0]    RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              regwrite,
   input  logic [4:0]        writereg,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] out0,
   output logic [DATA_W-1:0] out9,
   output logic [DATA_W-1:0] out18,
   output logic [DATA_W-1:0] out19,
   output logic [DATA_W-1:0] out20,
   output logic [DATA_W-1:0] out21,
   output logic [DATA_W-1:0] out22,
   output logic [DATA_W-1:0] out23,
   output logic [DATA_W-1:0] out24,
   output logic [DATA_W-1:0] out25,
   output logic [DATA_W-1:0] out26,
`ifdef REGBANK_ILLEGAL_WR_EN
   output logic [DATA_W-1:0] out27,
   output logic              illegal_wr,
   output logic [7:0]        illegal_cnt
`else
   output logic [DATA_W-1:0] out27
`endif
);

   logic [DATA_W-1:0] r_x9;
   logic [DATA_W-1:0] r_x [18:27];

   // Write is gated by regwrite first so X on writereg/writedata cannot reach state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x9 <= RESET_VALUE;
         for (int unsigned i = 18; i <= 27; i++) begin
            r_x[i] <= RESET_VALUE;
         end
      end else if (regwrite) begin
         if (writereg == 5'd9) begin
            r_x9 <= writedata;
         end
         for (int unsigned i = 18; i <= 27; i++) begin
            if (writereg == 5'(i)) begin
               r_x[i] <= writedata;
            end
         end
      end
   end

   assign out0  = '0;
   assign out9  = r_x9;
   assign out18 = r_x[18];
   assign out19 = r_x[19];
   assign out20 = r_x[20];
   assign out21 = r_x[21];
   assign out22 = r_x[22];
   assign out23 = r_x[23];
   assign out24 = r_x[24];
   assign out25 = r_x[25];
   assign out26 = r_x[26];
   assign out27 = r_x[27];

`ifdef REGBANK_ILLEGAL_WR_EN
   logic       w_legal;
   logic       r_illegal_wr;
   logic [7:0] r_illegal_cnt;

   assign w_legal = (writereg == 5'd0) || (writereg == 5'd9) ||
                    ((writereg >= 5'd18) && (writereg <= 5'd27));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_illegal_wr  <= 1'b0;
         r_illegal_cnt <= '0;
      end else if (regwrite && !w_legal) begin
         r_illegal_wr <= 1'b1;
         if (r_illegal_cnt != 8'hFF) begin
            r_illegal_cnt <= r_illegal_cnt + 8'd1;
         end
      end
   end

   assign illegal_wr  = r_illegal_wr;
   assign illegal_cnt = r_illegal_cnt;
`endif

endmodule

// File: tb/tb_reg_bank_store.sv
// Directed self-checking bench for reg_bank_store; illegal-write checks built when REGBANK_ILLEGAL_WR_EN is defined.
module tb_reg_bank_store;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        regwrite = 1'b0;
   logic [4:0]  writereg = '0;
   logic [31:0] writedata = '0;
   logic [31:0] out0, out9, out18, out19, out20, out21, out22, out23, out24, out25, out26, out27;
`ifdef REGBANK_ILLEGAL_WR_EN
   logic        illegal_wr;
   logic [7:0]  illegal_cnt;
`endif

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_v [0:31];
   int unsigned idx [0:11] = '{0, 9, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27};

   always #5 clk = ~clk;

   reg_bank_store #(.DATA_W(32), .RESET_VALUE(32'h0)) dut (
      .clk(clk), .rst(rst), .regwrite(regwrite), .writereg(writereg), .writedata(writedata),
      .out0(out0), .out9(out9), .out18(out18), .out19(out19), .out20(out20), .out21(out21),
      .out22(out22), .out23(out23), .out24(out24), .out25(out25), .out26(out26),
`ifdef REGBANK_ILLEGAL_WR_EN
      .out27(out27), .illegal_wr(illegal_wr), .illegal_cnt(illegal_cnt)
`else
      .out27(out27)
`endif
   );

   function automatic logic [31:0] get_out(int unsigned n);
      case (n)
         0:  return out0;
         9:  return out9;
         18: return out18;
         19: return out19;
         20: return out20;
         21: return out21;
         22: return out22;
         23: return out23;
         24: return out24;
         25: return out25;
         26: return out26;
         27: return out27;
         default: return 'x;
      endcase
   endfunction

   // Drive one cycle at negedge, settle just after the following rising edge.
   task automatic cycle(input logic r, input logic we, input logic [4:0] wr, input logic [31:0] wd);
      @(negedge clk);
      rst = r; regwrite = we; writereg = wr; writedata = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF);
      for (int k = 0; k < 32; k++) exp_v[k] = 32'h0;
      for (int k = 0; k < 12; k++) begin
         total++;
         if (get_out(idx[k]) !== exp_v[idx[k]]) begin
            bad++;
            $display("FAIL reset out%0d got=%h exp=%h", idx[k], get_out(idx[k]), exp_v[idx[k]]);
         end
      end
      cycle(1'b0, 1'b0, 5'd0, 32'h0);
   endtask

   task automatic test_write_latency();
      @(negedge clk);
      regwrite = 1'b1; writereg = 5'd18; writedata = 32'h1234_5678;
      #1;
      total++;
      if (out18 !== 32'h0) begin
         bad++;
         $display("FAIL no_bypass out18 got=%h exp=%h", out18, 32'h0);
      end
      @(posedge clk);
      #1;
      exp_v[18] = 32'h1234_5678;
      for (int k = 0; k < 12; k++) begin
         total++;
         if (get_out(idx[k]) !== exp_v[idx[k]]) begin
            bad++;
            $display("FAIL write_lat out%0d got=%h exp=%h", idx[k], get_out(idx[k]), exp_v[idx[k]]);
         end
      end
   endtask

   task automatic test_x0_unimpl();
      cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      for (int k = 0; k < 12; k++) begin
         total++;
         if (get_out(idx[k]) !== exp_v[idx[k]]) begin
            bad++;
            $display("FAIL x0_write out%0d got=%h exp=%h", idx[k], get_out(idx[k]), exp_v[idx[k]]);
         end
      end
`ifdef REGBANK_ILLEGAL_WR_EN
      total++;
      if (illegal_wr !== 1'b0) begin
         bad++;
         $display("FAIL x0_legal illegal_wr got=%b exp=0", illegal_wr);
      end
`endif
      cycle(1'b0, 1'b1, 5'd5, 32'hA5A5_A5A5);
      for (int k = 0; k < 12; k++) begin
         total++;
         if (get_out(idx[k]) !== exp_v[idx[k]]) begin
            bad++;
            $display("FAIL unimpl_write out%0d got=%h exp=%h", idx[k], get_out(idx[k]), exp_v[idx[k]]);
         end
      end
`ifdef REGBANK_ILLEGAL_WR_EN
      total++;
      if (illegal_wr !== 1'b1 || illegal_cnt !== 8'd1) begin
         bad++;
         $display("FAIL unimpl_flag got=%b/%0d exp=1/1", illegal_wr, illegal_cnt);
      end
`endif
   endtask

   task automatic test_sweep();
      for (int k = 1; k < 12; k++) begin
         cycle(1'b0, 1'b1, 5'(idx[k]), 32'(idx[k]));
         exp_v[idx[k]] = 32'(idx[k]);
      end
      for (int c = 0; c < 3; c++) begin
         cycle(1'b0, 1'b0, 5'($urandom_range(31, 0)), $urandom);
         for (int k = 0; k < 12; k++) begin
            total++;
            if (get_out(idx[k]) !== exp_v[idx[k]]) begin
               bad++;
               $display("FAIL sweep_hold c=%0d out%0d got=%h exp=%h", c, idx[k], get_out(idx[k]), exp_v[idx[k]]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int v = 1; v <= 3; v++) begin
         cycle(1'b0, 1'b1, 5'd27, 32'(v));
         total++;
         if (out27 !== 32'(v)) begin
            bad++;
            $display("FAIL b2b out27 got=%h exp=%h", out27, 32'(v));
         end
      end
      cycle(1'b1, 1'b1, 5'd27, 32'd4);
      for (int k = 0; k < 32; k++) exp_v[k] = 32'h0;
      for (int k = 0; k < 12; k++) begin
         total++;
         if (get_out(idx[k]) !== exp_v[idx[k]]) begin
            bad++;
            $display("FAIL b2b_rst out%0d got=%h exp=%h", idx[k], get_out(idx[k]), exp_v[idx[k]]);
         end
      end
      cycle(1'b0, 1'b1, 5'd27, 32'd5);
      total++;
      if (out27 !== 32'd5) begin
         bad++;
         $display("FAIL b2b_resume out27 got=%h exp=%h", out27, 32'd5);
      end
      exp_v[27] = 32'd5;
   endtask

`ifdef REGBANK_ILLEGAL_WR_EN
   task automatic test_illegal();
      cycle(1'b0, 1'b1, 5'd31, 32'h1111_1111);
      total++;
      if (illegal_wr !== 1'b1 || illegal_cnt !== 8'd1) begin
         bad++;
         $display("FAIL illegal_first got=%b/%0d exp=1/1", illegal_wr, illegal_cnt);
      end
      for (int n = 1; n < 300; n++) cycle(1'b0, 1'b1, 5'd31, 32'(n));
      total++;
      if (illegal_wr !== 1'b1 || illegal_cnt !== 8'hFF) begin
         bad++;
         $display("FAIL illegal_sat got=%b/%h exp=1/ff", illegal_wr, illegal_cnt);
      end
      for (int k = 0; k < 12; k++) begin
         total++;
         if (get_out(idx[k]) !== exp_v[idx[k]]) begin
            bad++;
            $display("FAIL illegal_hold out%0d got=%h exp=%h", idx[k], get_out(idx[k]), exp_v[idx[k]]);
         end
      end
      cycle(1'b1, 1'b0, 5'd0, 32'h0);
      total++;
      if (illegal_wr !== 1'b0 || illegal_cnt !== 8'h00) begin
         bad++;
         $display("FAIL illegal_rst got=%b/%h exp=0/00", illegal_wr, illegal_cnt);
      end
      cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      cycle(1'b0, 1'b0, 5'd0, 32'h0);
      total++;
      if (illegal_wr !== 1'b0 || illegal_cnt !== 8'h00 || out0 !== 32'h0) begin
         bad++;
         $display("FAIL illegal_x0 got=%b/%h/%h exp=0/00/0", illegal_wr, illegal_cnt, out0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write_latency();
      test_x0_unimpl();
      test_sweep();
      test_back_to_back();
`ifdef REGBANK_ILLEGAL_WR_EN
      test_illegal();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
